// File: rtl/wb_regfile.sv
// Write-back commit target: 32-entry GPR file with two bypassed read ports for
// decode, plus the HI/LO special registers (registered view only, no bypass).
module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              whilo,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic wr_en;
  assign wr_en = we && (waddr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en && (32'(waddr) < NUM_REGS)) regs_d[waddr] = wdata;
    regs_d[0] = '0;
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
    end
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (rst) begin
      hi_d = '0;
      lo_d = '0;
    end else if (whilo) begin
      hi_d = hi_i;
      lo_d = lo_i;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
    hi_q   <= hi_d;
    lo_q   <= lo_d;
  end

  // Read priority: reset, disable, r0, same-cycle bypass, then storage.
  // Addresses past NUM_REGS read zero so the path never resolves to X.
  always_comb begin
    rdata1 = '0;
    if (!rst && re1 && (raddr1 != '0)) begin
      if (we && (waddr == raddr1))       rdata1 = wdata;
      else if (32'(raddr1) < NUM_REGS)   rdata1 = regs_q[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (!rst && re2 && (raddr2 != '0)) begin
      if (we && (waddr == raddr2))       rdata2 = wdata;
      else if (32'(raddr2) < NUM_REGS)   rdata2 = regs_q[raddr2];
    end
  end

  assign hi_o = rst ? '0 : hi_q;
  assign lo_o = rst ? '0 : lo_q;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back destination for the pipeline: consumes the write-back bundle (destination address, write enable, data, HI/LO values, HI/LO write enable) and commits it to architectural state.
- Holds the 32-entry general register file with two read ports for the decode stage, plus the HI/LO special registers.
- Read ports include same-cycle write-to-read bypass, so decode sees a value being written back in that same cycle.

Parameters:
- DATA_W, 32, width of each register, write data, read data, HI and LO.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of general registers; index 0 is hardwired zero.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- we  input  1  general register write enable (from write-back).
- waddr  input  ADDR_W  general register write address.
- wdata  input  DATA_W  general register write data.
- re1  input  1  read port 1 enable.
- raddr1  input  ADDR_W  read port 1 address.
- rdata1  output  DATA_W  read port 1 data (combinational).
- re2  input  1  read port 2 enable.
- raddr2  input  ADDR_W  read port 2 address.
- rdata2  output  DATA_W  read port 2 data (combinational).
- whilo  input  1  HI/LO write enable (from write-back).
- hi_i  input  DATA_W  HI write value.
- lo_i  input  DATA_W  LO write value.
- hi_o  output  DATA_W  current HI (registered).
- lo_o  output  DATA_W  current LO (registered).

Behaviour:
- Reset: on a rising edge with rst=1, registers 1..NUM_REGS-1 clear to 0, and HI and LO clear to 0. All write inputs are ignored in that cycle.
- Reset outputs: while rst=1, rdata1, rdata2, hi_o and lo_o read 0, regardless of any other input.
- General write: at a rising edge with rst=0, we=1 and waddr!=0, reg[waddr] <= wdata. The new value is visible through storage from the next cycle.
- Writes to address 0 are discarded; reg[0] always reads 0.
- Read port n (n=1,2), combinational, priority order:
  1. rst=1 -> 0.
  2. ren=0 -> 0.
  3. raddrn=0 -> 0.
  4. we=1 and waddr==raddrn -> wdata (bypass, same cycle).
  5. Otherwise -> reg[raddrn].
- Both ports are independent. Both may read the same address, and both may bypass in the same cycle.
- HI/LO write: at a rising edge with rst=0 and whilo=1, HI <= hi_i and LO <= lo_i together; there is no partial update. With whilo=0, HI and LO hold their values.
- hi_o/lo_o reflect the stored registers only, with no bypass. They update one cycle after a whilo write; HI/LO forwarding is handled in the execute stage.
- General and HI/LO writes are independent and may occur in the same cycle.
- Reset mid-stream: a write presented in the same cycle as rst=1 is lost. The first post-reset cycle reads all zeros.
- No X propagation: every read path resolves to a defined value whenever the inputs are known.

Test Plan:
- Reset: preload reg5=0x1234 and HI=0xAAAA_0000. Assert rst for one edge with we=1, waddr=5, wdata=0xFFFF_FFFF. Afterwards rdata1 (re1=1, raddr1=5) = 0 and hi_o = 0; during rst, all outputs read 0.
- Write then read: write reg3=0xDEAD_BEEF. Next cycle, with re1=1 and raddr1=3, rdata1 = 0xDEAD_BEEF. With re1=0, rdata1 = 0.
- Bypass: we=1, waddr=7, wdata=0x0000_00A5, and in the same cycle re1=re2=1, raddr1=raddr2=7. Both ports read 0x0000_00A5 before the edge, and reg7 holds it after the edge.
- Zero register: we=1, waddr=0, wdata=0x5555_5555, and re1=1, raddr1=0 in the same cycle and the next. rdata1 = 0 in both cycles, with no bypass.
- HI/LO: whilo=1, hi_i=0x1111_1111, lo_i=0x2222_2222. In the same cycle hi_o/lo_o still show the old values; next cycle they show 0x1111_1111 and 0x2222_2222. Then whilo=0 with new inputs leaves them unchanged.
- Concurrent: in one cycle we=1, waddr=31, wdata=0xCAFE_0001, and whilo=1, hi_i=3, lo_i=4, with re2=1, raddr2=31. rdata2 bypasses 0xCAFE_0001; next cycle reg31=0xCAFE_0001, HI=3, LO=4.
